// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection and stall control.
//
// Purpose:
//   Captures decoded fields from ID into the EX stage. When the instruction in
//   ID reads a register that a load currently in EX will write, the stage holds
//   the front end (stall) and feeds STALL_CYCLES bubbles into EX before letting
//   the dependent instruction through. A flush kills whatever would enter EX.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               branch/jump redirect, kills the instruction entering EX
//   id_*                decoded instruction fields from ID
//   ex_*                registered copies of the ID fields (ex_rs/ex_rt go to
//                       the forwarding unit); ex_dst is the selected write reg
//   stall               hold PC and IF/ID this cycle
//   stall_count         saturating count of stalled cycles
//
// Parameters:
//   DATA_W              operand / immediate width
//   STALL_CYCLES        bubbles per load-use hazard, legal range 1..3
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W       = 32,
    parameter int STALL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic [3:0]        id_aluop,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_alusrc,
    output logic [3:0]        ex_aluop,
    output logic [4:0]        ex_dst,
    output logic              stall,
    output logic [15:0]       stall_count
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    // Counter preload on entering HOLD: the RUN cycle that detected the hazard
    // already supplies the first bubble, HOLD supplies the remaining ones.
    localparam logic [1:0] HOLD_INIT = (STALL_CYCLES > 1) ? 2'(STALL_CYCLES - 2) : 2'd0;

    logic [0:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [15:0]       stall_count_q;

    logic              ex_valid_q;
    logic [4:0]        ex_rs_q, ex_rt_q, ex_rd_q, ex_dst_q;
    logic [DATA_W-1:0] ex_rd1_q, ex_rd2_q, ex_imm_q;
    logic              ex_regwrite_q, ex_memread_q, ex_memwrite_q;
    logic              ex_memtoreg_q, ex_alusrc_q;
    logic [3:0]        ex_aluop_q;

    logic              hazard;
    logic              stall_d;
    logic              bubble;
    logic [4:0]        id_dst;

    assign id_dst = id_regdst ? id_rd : id_rt;

    // Load in EX whose result the ID instruction needs. A bubble in EX has
    // every field cleared, so it can never look like a load here.
    assign hazard = ex_valid_q & ex_memread_q & ex_regwrite_q & (ex_dst_q != 5'd0)
                  & id_valid
                  & ((id_rs == ex_dst_q) | (id_uses_rt & (id_rt == ex_dst_q)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = 1'b0;
        if (flush) begin
            state_d = S_RUN;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (hazard) begin
                        stall_d = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_d = S_HOLD;
                            cnt_d   = HOLD_INIT;
                        end
                    end
                end
                S_HOLD: begin
                    stall_d = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = S_RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // Whenever the front end is held or redirected, EX receives a bubble.
    assign bubble = flush | stall_d;

    // ---- control state ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RUN;
            cnt_q         <= 2'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_d && (stall_count_q != 16'hFFFF)) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    // ---- ID -> EX register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble) begin
            ex_valid_q    <= 1'b0;
            ex_rs_q       <= 5'd0;
            ex_rt_q       <= 5'd0;
            ex_rd_q       <= 5'd0;
            ex_dst_q      <= 5'd0;
            ex_rd1_q      <= '0;
            ex_rd2_q      <= '0;
            ex_imm_q      <= '0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
            ex_memtoreg_q <= 1'b0;
            ex_alusrc_q   <= 1'b0;
            ex_aluop_q    <= 4'd0;
        end else begin
            ex_valid_q    <= id_valid;
            ex_rs_q       <= id_rs;
            ex_rt_q       <= id_rt;
            ex_rd_q       <= id_rd;
            ex_dst_q      <= id_dst;
            ex_rd1_q      <= id_rd1;
            ex_rd2_q      <= id_rd2;
            ex_imm_q      <= id_imm;
            ex_regwrite_q <= id_regwrite;
            ex_memread_q  <= id_memread;
            ex_memwrite_q <= id_memwrite;
            ex_memtoreg_q <= id_memtoreg;
            ex_alusrc_q   <= id_alusrc;
            ex_aluop_q    <= id_aluop;
        end
    end

    // Reset forces stall low immediately even though it is combinational.
    assign stall       = stall_d & ~rst;
    assign stall_count = stall_count_q;

    assign ex_valid    = ex_valid_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_rd       = ex_rd_q;
    assign ex_dst      = ex_dst_q;
    assign ex_rd1      = ex_rd1_q;
    assign ex_rd2      = ex_rd2_q;
    assign ex_imm      = ex_imm_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_memread  = ex_memread_q;
    assign ex_memwrite = ex_memwrite_q;
    assign ex_memtoreg = ex_memtoreg_q;
    assign ex_alusrc   = ex_alusrc_q;
    assign ex_aluop    = ex_aluop_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage. Two instances share the ID inputs: u1 with
// STALL_CYCLES=1 and u3 with STALL_CYCLES=3. Expected EX contents are queued
// when stimulus is applied and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  dst;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        alusrc;
        logic [3:0]  aluop;
    } rec_t;

    typedef struct {
        int   dut;
        string tag;
        rec_t r;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        id_uses_rt = 1'b0;
    logic [31:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic        id_regwrite = 1'b0, id_memread = 1'b0, id_memwrite = 1'b0;
    logic        id_memtoreg = 1'b0, id_alusrc = 1'b0, id_regdst = 1'b0;
    logic [3:0]  id_aluop = '0;

    logic        a_valid, a_regwrite, a_memread, a_memwrite, a_memtoreg, a_alusrc, a_stall;
    logic [4:0]  a_rs, a_rt, a_rd, a_dst;
    logic [31:0] a_rd1, a_rd2, a_imm;
    logic [3:0]  a_aluop;
    logic [15:0] a_cnt;

    logic        b_valid, b_regwrite, b_memread, b_memwrite, b_memtoreg, b_alusrc, b_stall;
    logic [4:0]  b_rs, b_rt, b_rd, b_dst;
    logic [31:0] b_rd1, b_rd2, b_imm;
    logic [3:0]  b_aluop;
    logic [15:0] b_cnt;

    rec_t obs1, obs3;
    sb_t  sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .STALL_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
        .id_aluop(id_aluop),
        .ex_valid(a_valid), .ex_rs(a_rs), .ex_rt(a_rt), .ex_rd(a_rd),
        .ex_rd1(a_rd1), .ex_rd2(a_rd2), .ex_imm(a_imm),
        .ex_regwrite(a_regwrite), .ex_memread(a_memread), .ex_memwrite(a_memwrite),
        .ex_memtoreg(a_memtoreg), .ex_alusrc(a_alusrc), .ex_aluop(a_aluop),
        .ex_dst(a_dst), .stall(a_stall), .stall_count(a_cnt)
    );

    id_ex_stage #(.DATA_W(32), .STALL_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
        .id_aluop(id_aluop),
        .ex_valid(b_valid), .ex_rs(b_rs), .ex_rt(b_rt), .ex_rd(b_rd),
        .ex_rd1(b_rd1), .ex_rd2(b_rd2), .ex_imm(b_imm),
        .ex_regwrite(b_regwrite), .ex_memread(b_memread), .ex_memwrite(b_memwrite),
        .ex_memtoreg(b_memtoreg), .ex_alusrc(b_alusrc), .ex_aluop(b_aluop),
        .ex_dst(b_dst), .stall(b_stall), .stall_count(b_cnt)
    );

    assign obs1 = {a_valid, a_rs, a_rt, a_rd, a_dst, a_rd1, a_rd2, a_imm,
                   a_regwrite, a_memread, a_memwrite, a_memtoreg, a_alusrc, a_aluop};
    assign obs3 = {b_valid, b_rs, b_rt, b_rd, b_dst, b_rd1, b_rd2, b_imm,
                   b_regwrite, b_memread, b_memwrite, b_memtoreg, b_alusrc, b_aluop};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input rec_t obs, input rec_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one ID instruction. ld selects a load-shaped control set.
    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic uses_rt, input logic regdst,
                          input logic ld, input logic [31:0] d1);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_uses_rt  = uses_rt;
        id_regdst   = regdst;
        id_rd1      = d1;
        id_rd2      = d1 ^ 32'h0000_FF00;
        id_imm      = d1 + 32'h0000_1000;
        id_regwrite = 1'b1;
        id_memread  = ld;
        id_memtoreg = ld;
        id_alusrc   = ld;
        id_memwrite = 1'b0;
        id_aluop    = ld ? 4'h2 : 4'h6;
    endtask

    // Expected EX contents if the current ID instruction is accepted.
    function automatic rec_t id_rec();
        rec_t r;
        r.valid    = id_valid;
        r.rs       = id_rs;
        r.rt       = id_rt;
        r.rd       = id_rd;
        r.dst      = id_regdst ? id_rd : id_rt;
        r.rd1      = id_rd1;
        r.rd2      = id_rd2;
        r.imm      = id_imm;
        r.regwrite = id_regwrite;
        r.memread  = id_memread;
        r.memwrite = id_memwrite;
        r.memtoreg = id_memtoreg;
        r.alusrc   = id_alusrc;
        r.aluop    = id_aluop;
        return r;
    endfunction

    task automatic push(input int dut, input string tag, input rec_t r);
        sb_t e;
        e.dut = dut;
        e.tag = tag;
        e.r   = r;
        sb.push_back(e);
    endtask

    // Settle inputs, check combinational stall, queue EX expectation, clock.
    task automatic step(input int dut, input string tag, input logic exp_stall, input logic accept);
        #1;
        chk({tag, "_stall"}, {31'd0, (dut == 1) ? a_stall : b_stall}, {31'd0, exp_stall});
        push(dut, {tag, "_ex"}, accept ? id_rec() : rec_t'('0));
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            chk_rec(e.tag, (e.dut == 1) ? obs1 : obs3, e.r);
        end
    endtask

    initial begin
        // ---- reset ----
        repeat (2) @(posedge clk);
        #1;
        chk_rec("rst_ex_u1", obs1, rec_t'('0));
        chk_rec("rst_ex_u3", obs3, rec_t'('0));
        chk("rst_stall_u1", {31'd0, a_stall}, 32'd0);
        chk("rst_cnt_u1", {16'd0, a_cnt}, 32'd0);
        chk("rst_cnt_u3", {16'd0, b_cnt}, 32'd0);
        rst = 1'b0;

        // ---- STALL_CYCLES=1 instance ----
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1, "idle", 1'b0, 1'b1);
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 32'h11);
        step(1, "pass", 1'b0, 1'b1);
        chk("pass_rs", {27'd0, a_rs}, 32'd3);
        chk("pass_rt", {27'd0, a_rt}, 32'd4);
        chk("pass_dst", {27'd0, a_dst}, 32'd5);
        chk("pass_rd1", a_rd1, 32'h11);
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 32'h44);
        step(1, "lw8", 1'b0, 1'b1);
        set_id(1'b1, 5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 32'h55);
        step(1, "lu1_hold", 1'b1, 1'b0);
        step(1, "lu1_issue", 1'b0, 1'b1);
        chk("lu1_cnt", {16'd0, a_cnt}, 32'd1);
        // load to r0 followed by a reader of r0
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h66);
        step(1, "lw0", 1'b0, 1'b1);
        set_id(1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 32'h77);
        step(1, "r0_use", 1'b0, 1'b1);
        // load to r9 followed by an instruction whose rt field is 9 but unused
        set_id(1'b1, 5'd1, 5'd9, 5'd12, 1'b0, 1'b1, 1'b0, 32'h88);
        step(1, "rt_unused", 1'b0, 1'b1);
        // flush on top of a real hazard
        set_id(1'b1, 5'd2, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 32'h99);
        step(1, "lw7", 1'b0, 1'b1);
        set_id(1'b1, 5'd4, 5'd7, 5'd13, 1'b1, 1'b1, 1'b0, 32'hAA);
        flush = 1'b1;
        step(1, "flush_haz", 1'b0, 1'b0);
        flush = 1'b0;
        chk("flush_cnt", {16'd0, a_cnt}, 32'd1);
        // saturation: preload the counter near its ceiling
        force u1.stall_count_q = 16'hFFFE;
        #1;
        release u1.stall_count_q;
        #1;
        chk("sat_preload", {16'd0, a_cnt}, 32'h0000_FFFE);
        set_id(1'b1, 5'd1, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 32'hB0);
        step(1, "sat_lw_a", 1'b0, 1'b1);
        set_id(1'b1, 5'd6, 5'd1, 5'd14, 1'b1, 1'b1, 1'b0, 32'hB1);
        step(1, "sat_use_a", 1'b1, 1'b0);
        chk("sat_ffff", {16'd0, a_cnt}, 32'h0000_FFFF);
        set_id(1'b1, 5'd1, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 32'hB2);
        step(1, "sat_lw_b", 1'b0, 1'b1);
        set_id(1'b1, 5'd6, 5'd1, 5'd14, 1'b1, 1'b1, 1'b0, 32'hB3);
        step(1, "sat_use_b", 1'b1, 1'b0);
        chk("sat_hold", {16'd0, a_cnt}, 32'h0000_FFFF);

        // ---- STALL_CYCLES=3 instance ----
        rst = 1'b1;
        #1;
        rst = 1'b0;
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 32'h44);
        step(3, "l3_lw", 1'b0, 1'b1);
        set_id(1'b1, 5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 32'h55);
        step(3, "l3_b1", 1'b1, 1'b0);
        step(3, "l3_b2", 1'b1, 1'b0);
        step(3, "l3_b3", 1'b1, 1'b0);
        chk("l3_cnt", {16'd0, b_cnt}, 32'd3);
        step(3, "l3_issue", 1'b0, 1'b1);
        // flush on the second stall cycle
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 32'h45);
        step(3, "fh_lw", 1'b0, 1'b1);
        set_id(1'b1, 5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 32'h56);
        step(3, "fh_b1", 1'b1, 1'b0);
        flush = 1'b1;
        step(3, "fh_flush", 1'b0, 1'b0);
        flush = 1'b0;
        step(3, "fh_run", 1'b0, 1'b1);
        chk("fh_cnt", {16'd0, b_cnt}, 32'd4);
        // asynchronous reset while EX holds a valid instruction
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 32'h46);
        step(3, "ar_lw", 1'b0, 1'b1);
        set_id(1'b1, 5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 32'h57);
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'd0, b_valid}, 32'd0);
        chk("ar_stall", {31'd0, b_stall}, 32'd0);
        chk("ar_cnt", {16'd0, b_cnt}, 32'd0);
        rst = 1'b0;
        // asynchronous reset in the middle of HOLD
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 32'h47);
        step(3, "rh_lw", 1'b0, 1'b1);
        set_id(1'b1, 5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 32'h58);
        step(3, "rh_b1", 1'b1, 1'b0);
        #1;
        chk("rh_hold_stall", {31'd0, b_stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rh_rst_stall", {31'd0, b_stall}, 32'd0);
        chk("rh_rst_cnt", {16'd0, b_cnt}, 32'd0);
        rst = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(3, "rh_after", 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
